// File: rtl/biriscv_fetch_unit_if.sv
// Signal bundle between the fetch unit and its neighbours: branch redirect,
// predictor lookup, instruction cache request/response and decode handshake.
interface biriscv_fetch_unit_if;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic [1:0]  branch_priv_i;
  logic [31:0] next_pc_f_i;
  logic [1:0]  next_taken_f_i;
  logic [31:0] pc_f_o;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic        icache_error_i;
  logic        icache_page_fault_i;
  logic [63:0] icache_inst_i;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic        fetch_accept_i;

  modport master (
    input  branch_request_i, branch_pc_i, branch_priv_i, next_pc_f_i, next_taken_f_i,
           icache_accept_i, icache_valid_i, icache_error_i, icache_page_fault_i,
           icache_inst_i, fetch_accept_i,
    output pc_f_o, icache_rd_o, icache_pc_o, icache_priv_o, fetch_valid_o, fetch_instr_o,
           fetch_pc_o, fetch_pred_branch_o, fetch_fault_fetch_o, fetch_fault_page_o
  );

  modport slave (
    output branch_request_i, branch_pc_i, branch_priv_i, next_pc_f_i, next_taken_f_i,
           icache_accept_i, icache_valid_i, icache_error_i, icache_page_fault_i,
           icache_inst_i, fetch_accept_i,
    input  pc_f_o, icache_rd_o, icache_pc_o, icache_priv_o, fetch_valid_o, fetch_instr_o,
           fetch_pc_o, fetch_pred_branch_o, fetch_fault_fetch_o, fetch_fault_page_o
  );
endinterface

// File: rtl/biriscv_fetch_unit.sv
// Fetch engine: one outstanding 8-byte icache request, pass-through response
// path to decode with a one-entry skid buffer, and branch redirect/discard.
module biriscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                  clk_i,
  input logic                  rst_i,
  biriscv_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, STALL} state_t;

  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        err;
    logic        pf;
  } bundle_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  priv_q, priv_d;
  logic        discard_q, discard_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  req_pred_q, req_pred_d;
  bundle_t     skid_q, skid_d;

  logic        rd, acc, resp, pass, branch;
  logic [31:0] pc_inc;
  bundle_t     resp_bun, out_bun;

  always_comb begin
    branch   = bus.branch_request_i;
    rd       = (state_q == REQ) && !branch;
    acc      = rd && bus.icache_accept_i;
    resp     = (state_q == WAIT) && bus.icache_valid_i;
    // A response racing a redirect is dropped outright, so no discard is armed.
    pass     = resp && !discard_q && !branch;
    pc_inc   = {pc_q[31:3] + 29'd1, 3'b000};
    resp_bun = '{instr: bus.icache_inst_i, pc: req_pc_q, pred: req_pred_q,
                 err: bus.icache_error_i, pf: bus.icache_page_fault_i};
    out_bun  = pass ? resp_bun : skid_q;

    state_d    = state_q;
    pc_d       = pc_q;
    priv_d     = priv_q;
    discard_d  = discard_q;
    req_pc_d   = req_pc_q;
    req_pred_d = req_pred_q;
    skid_d     = skid_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (acc) begin
          state_d    = WAIT;
          req_pc_d   = pc_q;
          req_pred_d = bus.next_taken_f_i;
          pc_d       = (|bus.next_taken_f_i) ? bus.next_pc_f_i : pc_inc;
        end
      end
      WAIT: begin
        if (resp) begin
          discard_d = 1'b0;
          if (pass && !bus.fetch_accept_i) begin
            state_d = STALL;
            skid_d  = resp_bun;
          end else begin
            state_d = REQ;
          end
        end else if (branch) begin
          discard_d = 1'b1;
        end
      end
      STALL: if (bus.fetch_accept_i) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (branch) begin
      pc_d   = bus.branch_pc_i;
      priv_d = bus.branch_priv_i;
      if (state_q == STALL) state_d = REQ;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      priv_q     <= 2'b11;
      discard_q  <= 1'b0;
      req_pc_q   <= '0;
      req_pred_q <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      priv_q     <= priv_d;
      discard_q  <= discard_d;
      req_pc_q   <= req_pc_d;
      req_pred_q <= req_pred_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.pc_f_o              = pc_q;
  assign bus.icache_rd_o         = rd;
  assign bus.icache_pc_o         = {pc_q[31:3], 3'b000};
  assign bus.icache_priv_o       = priv_q;
  assign bus.fetch_valid_o       = pass || ((state_q == STALL) && !branch);
  assign bus.fetch_instr_o       = out_bun.instr;
  assign bus.fetch_pc_o          = out_bun.pc;
  assign bus.fetch_pred_branch_o = out_bun.pred;
  assign bus.fetch_fault_fetch_o = out_bun.err;
  assign bus.fetch_fault_page_o  = out_bun.pf;

endmodule
